// File: rtl/mem_subword_ctrl_if.sv
//------------------------------------------------------------------------------
// mem_subword_ctrl_if
// CPU-side and memory-side bus bundle for the sub-word memory sequencer.
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface mem_subword_ctrl_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_size;
    logic        cpu_signed;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_done;
    logic        cpu_err;
    logic        busy;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    // Environment side: drives CPU requests and memory responses.
    modport master (
        output cpu_req, cpu_we, cpu_size, cpu_signed, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_done, cpu_err, busy,
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );

    // Controller side.
    modport slave (
        input  cpu_req, cpu_we, cpu_size, cpu_signed, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_done, cpu_err, busy,
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );
endinterface

`default_nettype wire

// File: rtl/mem_subword_ctrl.sv
//------------------------------------------------------------------------------
// mem_subword_ctrl
// Byte/half/word load-store sequencer over a word-wide memory (RMW for sub-word stores).
// Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_subword_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    mem_subword_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_MERGE = 3'd2,
        S_WR    = 3'd3,
        S_FIN   = 3'd4,
        S_ERR   = 3'd5
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d;
    logic [1:0]  lane_q, lane_d;
    logic [15:0] wdata_q, wdata_d;
    logic [31:0] word_q, word_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic        mreq_q, mreq_d;
    logic        mwe_q, mwe_d;
    logic [31:0] maddr_q, maddr_d;
    logic [31:0] mwdata_q, mwdata_d;
    logic [8:0]  cnt_inc;

    function automatic logic f_misaligned(input logic [1:0] sz, input logic [1:0] a);
        f_misaligned = (sz == 2'b11) || ((sz == 2'b01) && a[0]) || ((sz == 2'b10) && (a != 2'b00));
    endfunction

    function automatic logic [31:0] f_extend(input logic [31:0] w, input logic [1:0] sz,
                                             input logic sg, input logic [1:0] a);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00:   f_extend = {{24{sg & b[7]}}, b};
            2'b01:   f_extend = {{16{sg & h[15]}}, h};
            default: f_extend = w;
        endcase
    endfunction

    function automatic logic [31:0] f_merge(input logic [31:0] w, input logic [15:0] d,
                                            input logic [1:0] sz, input logic [1:0] a);
        f_merge = w;
        if (sz == 2'b00) begin
            f_merge[{a, 3'b000} +: 8] = d[7:0];
        end else if (a[1]) begin
            f_merge[31:16] = d;
        end else begin
            f_merge[15:0] = d;
        end
    endfunction

    assign cnt_inc = {1'b0, cnt_q} + 9'd1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'b00;
            sgn_q    <= 1'b0;
            lane_q   <= 2'b00;
            wdata_q  <= '0;
            word_q   <= '0;
            cnt_q    <= '0;
            rdata_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            mreq_q   <= 1'b0;
            mwe_q    <= 1'b0;
            maddr_q  <= '0;
            mwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            sgn_q    <= sgn_d;
            lane_q   <= lane_d;
            wdata_q  <= wdata_d;
            word_q   <= word_d;
            cnt_q    <= cnt_d;
            rdata_q  <= rdata_d;
            done_q   <= done_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            mreq_q   <= mreq_d;
            mwe_q    <= mwe_d;
            maddr_q  <= maddr_d;
            mwdata_q <= mwdata_d;
        end
    end

    // Outputs are computed alongside the next state so every port is a flop.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        sgn_d    = sgn_q;
        lane_d   = lane_q;
        wdata_d  = wdata_q;
        word_d   = word_q;
        cnt_d    = cnt_q;
        rdata_d  = rdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        mreq_d   = mreq_q;
        mwe_d    = mwe_q;
        maddr_d  = maddr_q;
        mwdata_d = mwdata_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cpu_req) begin
                    we_d    = bus.cpu_we;
                    size_d  = bus.cpu_size;
                    sgn_d   = bus.cpu_signed;
                    lane_d  = bus.cpu_addr[1:0];
                    wdata_d = bus.cpu_wdata[15:0];
                    cnt_d   = '0;
                    if (f_misaligned(bus.cpu_size, bus.cpu_addr[1:0])) begin
                        state_d = S_ERR;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end else begin
                        mreq_d  = 1'b1;
                        maddr_d = {bus.cpu_addr[31:2], 2'b00};
                        if (bus.cpu_we && (bus.cpu_size == 2'b10)) begin
                            state_d  = S_WR;
                            mwe_d    = 1'b1;
                            mwdata_d = bus.cpu_wdata;
                        end else begin
                            state_d = S_RD;
                            mwe_d   = 1'b0;
                        end
                    end
                end
            end
            S_RD, S_WR: begin
                if (bus.mem_ack) begin
                    mreq_d = 1'b0;
                    mwe_d  = 1'b0;
                    if ((state_q == S_RD) && we_q) begin
                        state_d = S_MERGE;
                        word_d  = bus.mem_rdata;
                    end else begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        if (state_q == S_RD) begin
                            rdata_d = f_extend(bus.mem_rdata, size_q, sgn_q, lane_q);
                        end
                    end
                end else if (cnt_inc == 9'(TIMEOUT)) begin
                    state_d = S_ERR;
                    mreq_d  = 1'b0;
                    mwe_d   = 1'b0;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc[7:0];
                end
            end
            S_MERGE: begin
                state_d  = S_WR;
                mreq_d   = 1'b1;
                mwe_d    = 1'b1;
                mwdata_d = f_merge(word_q, wdata_q, size_q, lane_q);
                cnt_d    = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.cpu_rdata = rdata_q;
    assign bus.cpu_done  = done_q;
    assign bus.cpu_err   = err_q;
    assign bus.busy      = busy_q;
    assign bus.mem_req   = mreq_q;
    assign bus.mem_we    = mwe_q;
    assign bus.mem_addr  = maddr_q;
    assign bus.mem_wdata = mwdata_q;

endmodule

`default_nettype wire
